// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, edge capture, wake pending flag and CPU dispatch.
// Optional build macro GB_IRQ_SVC_COUNT_EN adds five 8-bit saturating per-source service counters.
module gb_irq_ctrl #(
    parameter int         DISPATCH_TICKS = 3,
    parameter logic [7:0] VEC_BASE       = 8'h40,
    parameter int         VEC_STRIDE     = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic [4:0]  irq_src,
    input  logic        cpu_sel_if,
    input  logic        cpu_sel_ie,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do_if,
    output logic [7:0]  cpu_do_ie,
    output logic        irq_pending,
    input  logic        cpu_ack,
    output logic        busy,
    output logic        irq_vec_valid,
    output logic [7:0]  irq_vec,
    output logic [39:0] svc_count
);

    localparam logic [2:0] DISPATCH_LAST = 3'(DISPATCH_TICKS);
    localparam logic [7:0] STRIDE8       = 8'(VEC_STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;

    logic [4:0]  src_r;
    logic [4:0]  rise;
    logic [4:0]  if_r;
    logic [4:0]  if_next;
    logic [7:0]  ie_r;
    logic [4:0]  pending;
    logic [4:0]  lowest_oh;
    logic [2:0]  sel_k;
    logic [7:0]  resolved_vec;
    logic [7:0]  vec_r;
    logic        resolving;
    logic        resolve_tick;

    // ---------------- dispatch FSM: state register ----------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else if (ce) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ---------------- dispatch FSM: next state ----------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                // Accepted even with nothing pending; that path ends in a cancellation.
                if (cpu_ack) begin
                    state_next = ST_WAIT;
                    cnt_next   = 3'd1;
                end
            end
            ST_WAIT: begin
                if (cnt == DISPATCH_LAST) begin
                    state_next = ST_RESOLVE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            ST_RESOLVE: begin
                state_next = ST_IDLE;
                cnt_next   = 3'd0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // ---------------- dispatch FSM: outputs ----------------
    always_comb begin
        busy          = (state != ST_IDLE);
        resolving     = (state == ST_RESOLVE);
        resolve_tick  = ce & resolving;
        irq_vec_valid = resolve_tick;
    end

    // Edge capture: a held line sets IF once, a single-tick pulse is never lost.
    assign rise = irq_src & ~src_r;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            src_r <= 5'h00;
        end else if (ce) begin
            src_r <= irq_src;
        end
    end

    assign pending     = if_r & ie_r[4:0];
    assign irq_pending = |pending;

    // Lowest set bit wins; one-hot form drives the IF clear directly.
    assign lowest_oh = pending & (~pending + 5'd1);

    always_comb begin
        sel_k = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                sel_k = 3'(i);
            end
        end
    end

    assign resolved_vec = irq_pending ? (VEC_BASE + STRIDE8 * {5'd0, sel_k}) : 8'h00;

    // Write first, then dispatch clear, then new rises, so a same-tick request survives.
    always_comb begin
        if_next = if_r;
        if (cpu_sel_if && cpu_wr) begin
            if_next = cpu_di[4:0];
        end
        if (resolve_tick) begin
            if_next = if_next & ~lowest_oh;
        end
        if_next = if_next | rise;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            if_r <= 5'h00;
            ie_r <= 8'h00;
        end else if (ce) begin
            if_r <= if_next;
            if (cpu_sel_ie && cpu_wr) begin
                ie_r <= cpu_di;
            end
        end
    end

    assign cpu_do_if = {3'b111, if_r};
    assign cpu_do_ie = ie_r;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vec_r <= 8'h00;
        end else if (resolve_tick) begin
            vec_r <= resolved_vec;
        end
    end

    // The freshly resolved vector is visible during the resolution tick itself.
    assign irq_vec = resolving ? resolved_vec : vec_r;

`ifdef GB_IRQ_SVC_COUNT_EN
    logic [7:0] svc_cnt [5];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 0; k < 5; k++) begin
                svc_cnt[k] <= 8'h00;
            end
        end else if (resolve_tick) begin
            for (int k = 0; k < 5; k++) begin
                if (lowest_oh[k] && (svc_cnt[k] != 8'hFF)) begin
                    svc_cnt[k] <= svc_cnt[k] + 8'd1;
                end
            end
        end
    end

    assign svc_count = {svc_cnt[4], svc_cnt[3], svc_cnt[2], svc_cnt[1], svc_cnt[0]};
`else
    assign svc_count = 40'h0;
`endif

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed bench for gb_irq_ctrl: vector table for the main flow plus hand sequences for races,
// cancellation, reset mid-dispatch and (with GB_IRQ_SVC_COUNT_EN) counter saturation.
module tb_gb_irq_ctrl;

    logic        clk_sys;
    logic        reset;
    logic        ce;
    logic [4:0]  irq_src;
    logic        cpu_sel_if;
    logic        cpu_sel_ie;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do_if;
    logic [7:0]  cpu_do_ie;
    logic        irq_pending;
    logic        cpu_ack;
    logic        busy;
    logic        irq_vec_valid;
    logic [7:0]  irq_vec;
    logic [39:0] svc_count;

    int checks = 0;
    int errors = 0;

    gb_irq_ctrl dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce            (ce),
        .irq_src       (irq_src),
        .cpu_sel_if    (cpu_sel_if),
        .cpu_sel_ie    (cpu_sel_ie),
        .cpu_wr        (cpu_wr),
        .cpu_di        (cpu_di),
        .cpu_do_if     (cpu_do_if),
        .cpu_do_ie     (cpu_do_ie),
        .irq_pending   (irq_pending),
        .cpu_ack       (cpu_ack),
        .busy          (busy),
        .irq_vec_valid (irq_vec_valid),
        .irq_vec       (irq_vec),
        .svc_count     (svc_count)
    );

    // ---------------- clock / reset ----------------
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0] src;
        logic       ack;
        logic       sel_if;
        logic       sel_ie;
        logic       wr;
        logic [7:0] di;
        logic [7:0] e_if;
        logic [7:0] e_ie;
        logic       e_pend;
        logic       e_busy;
        logic       e_valid;
        logic [7:0] e_vec;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic [4:0] src, input logic ack, input logic sel_if,
                                input logic sel_ie, input logic wr, input logic [7:0] di,
                                input logic [7:0] e_if, input logic [7:0] e_ie, input logic e_pend,
                                input logic e_busy, input logic e_valid, input logic [7:0] e_vec);
        vec_t v;
        v.src = src; v.ack = ack; v.sel_if = sel_if; v.sel_ie = sel_ie; v.wr = wr; v.di = di;
        v.e_if = e_if; v.e_ie = e_ie; v.e_pend = e_pend; v.e_busy = e_busy;
        v.e_valid = e_valid; v.e_vec = e_vec;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic [4:0] src, input logic ack, input logic sel_if,
                         input logic sel_ie, input logic wr, input logic [7:0] di);
        irq_src    = src;
        cpu_ack    = ack;
        cpu_sel_if = sel_if;
        cpu_sel_ie = sel_ie;
        cpu_wr     = wr;
        cpu_di     = di;
    endtask

    task automatic idle_inputs();
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int valid_seen;

    initial begin
        // Table: held source, IF write, timer dispatch, then two-step priority dispatch.
        //                 src    ack   sif   sie   wr    di      e_if   e_ie   pnd   bsy   vld   vec
        tbl[0]  = mk(5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mk(5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[2]  = mk(5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[3]  = mk(5'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[4]  = mk(5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[5]  = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[6]  = mk(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'hE0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[7]  = mk(5'h04, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE4, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[8]  = mk(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE4, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00);
        tbl[9]  = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE4, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00);
        tbl[10] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE4, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00);
        tbl[11] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE4, 8'h04, 1'b1, 1'b1, 1'b1, 8'h50);
        tbl[12] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hE0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h50);
        tbl[13] = mk(5'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1E, 8'hFE, 8'h04, 1'b1, 1'b0, 1'b0, 8'h50);
        tbl[14] = mk(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 8'hFE, 8'h1F, 1'b1, 1'b0, 1'b0, 8'h50);
        tbl[15] = mk(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h50);
        tbl[16] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h50);
        tbl[17] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h50);
        tbl[18] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFE, 8'h1F, 1'b1, 1'b1, 1'b1, 8'h48);
        tbl[19] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 8'h1F, 1'b1, 1'b0, 1'b0, 8'h48);
        tbl[20] = mk(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h48);
        tbl[21] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h48);
        tbl[22] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 8'h1F, 1'b1, 1'b1, 1'b0, 8'h48);
        tbl[23] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 8'h1F, 1'b1, 1'b1, 1'b1, 8'h50);
        tbl[24] = mk(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF8, 8'h1F, 1'b1, 1'b0, 1'b0, 8'h50);

        reset = 1'b1;
        ce    = 1'b1;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_if", cpu_do_if, 8'hE0);
        chk("rst_ie", cpu_do_ie, 8'h00);
        chk("rst_pending", irq_pending, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", irq_vec_valid, 1'b0);
        chk("rst_vec", irq_vec, 8'h00);
        chk("rst_svc", svc_count, 40'h0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].src, tbl[i].ack, tbl[i].sel_if, tbl[i].sel_ie, tbl[i].wr, tbl[i].di);
            tick();
            chk($sformatf("v%0d_if", i), cpu_do_if, tbl[i].e_if);
            chk($sformatf("v%0d_ie", i), cpu_do_ie, tbl[i].e_ie);
            chk($sformatf("v%0d_pending", i), irq_pending, tbl[i].e_pend);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_valid", i), irq_vec_valid, tbl[i].e_valid);
            chk($sformatf("v%0d_vec", i), irq_vec, tbl[i].e_vec);
        end
        idle_inputs();

        // Cancellation: IE cleared while counter==2, plus ce gating of the valid pulse.
        drive(5'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01); tick();
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01); tick();
        drive(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle_inputs(); tick();
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00); tick();
        idle_inputs(); tick();
        ce = 1'b0;
        #1;
        chk("cancel_valid_ce_low", irq_vec_valid, 1'b0);
        tick();
        chk("cancel_stall_busy", busy, 1'b1);
        chk("cancel_stall_valid", irq_vec_valid, 1'b0);
        ce = 1'b1;
        #1;
        chk("cancel_valid", irq_vec_valid, 1'b1);
        chk("cancel_vec", irq_vec, 8'h00);
        tick();
        chk("cancel_if_kept", cpu_do_if, 8'hE1);
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_vec_held", irq_vec, 8'h00);
        chk("cancel_valid_off", irq_vec_valid, 1'b0);

        // Race: CPU writes IF=0 in the same tick a serial request rises.
        drive(5'h08, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); tick();
        chk("race_wr_if", cpu_do_if, 8'hE8);
        idle_inputs(); tick();

        // Race: VBlank rises in the resolution tick that clears bit 0.
        drive(5'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01); tick();
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01); tick();
        drive(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle_inputs();
        repeat (3) tick();
        chk("race_res_valid", irq_vec_valid, 1'b1);
        chk("race_res_vec", irq_vec, 8'h40);
        drive(5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("race_res_if", cpu_do_if, 8'hE1);
        chk("race_res_pending", irq_pending, 1'b1);
        chk("race_res_busy", busy, 1'b0);
        idle_inputs(); tick();

        // Reset asserted at counter==2 aborts the dispatch.
        drive(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle_inputs(); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_if", cpu_do_if, 8'hE0);
        chk("mid_rst_ie", cpu_do_ie, 8'h00);
        chk("mid_rst_vec", irq_vec, 8'h00);
        chk("mid_rst_svc", svc_count, 40'h0);
        valid_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (irq_vec_valid) valid_seen++;
            tick();
        end
        chk("mid_rst_no_valid", valid_seen, 0);

`ifdef GB_IRQ_SVC_COUNT_EN
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10); tick();
        idle_inputs();
        for (int n = 1; n <= 300; n++) begin
            drive(5'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
            drive(5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
            idle_inputs();
            repeat (3) tick();
            if (n == 1) chk("svc_joy_vec", irq_vec, 8'h60);
            tick();
            if (n == 100) chk("svc_joy_100", svc_count, {8'd100, 32'h0});
        end
        chk("svc_joy_sat", svc_count, {8'hFF, 32'h0});
`else
        chk("svc_tied_off", svc_count, 40'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
